dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit words in the attached data memory.
REQ-002 SHALL have parameter RD_LAT, default 1, range 1..15, meaning cycles Erd is held before MOut is sampled.
REQ-003 SHALL have port Clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ReqVal  input  1  request valid from pipeline.
REQ-006 SHALL have port ReqRdy  output  1  controller can accept a request.
REQ-007 SHALL have port ReqWr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port ReqAddr  input  32  byte address.
REQ-009 SHALL have port ReqData  input  32  store data.
REQ-010 SHALL have port RspVal  output  1  response valid.
REQ-011 SHALL have port RspRdy  input  1  pipeline accepts response.
REQ-012 SHALL have port RspData  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port RspErr  output  1  request rejected (misaligned or out of range).
REQ-014 SHALL have ports Ewr output 1, Erd output 1, Addr output 32 (word index), RDir output 32 (write data), MOut input 32 (read data) toward the data memory.

Function
REQ-015 SHALL implement FSM states IDLE, WR, RD, RESP, ERR; ReqRdy = 1 only in IDLE.
REQ-016 SHALL, in IDLE with ReqVal=1, register ReqWr/ReqAddr/ReqData (handshake on ReqVal&ReqRdy) and move to ERR if ReqAddr[1:0]!=0, else WR if ReqWr=1, else RD.
REQ-017 SHALL drive Addr = ReqAddr[31:2] zero-extended, registered at acceptance, stable for the whole transaction.
REQ-018 SHALL, in WR, assert Ewr=1 and RDir=captured data for exactly one cycle, then go to RESP with RspData=0, RspErr=0.
REQ-019 SHALL, in RD, assert Erd=1 for exactly RD_LAT cycles (4-bit down-counter), sample MOut into RspData on the last of those cycles, then go to RESP.
REQ-020 SHALL, in RESP and ERR, hold RspVal=1 and RspData/RspErr stable until RspRdy=1, then return to IDLE on that edge.
REQ-021 SHALL, in ERR, drive RspErr=1, RspData=0, and never assert Ewr or Erd.
REQ-022 SHALL never assert Ewr and Erd in the same cycle; both SHALL be 0 outside WR/RD; RDir SHALL be 0 outside WR.
REQ-023 SHALL ignore ReqVal outside IDLE (no queueing); a new request is accepted no earlier than the cycle after the RspVal&RspRdy handshake.
REQ-024 SHALL give load latency acceptance-to-RspVal of RD_LAT+1 cycles and store latency of 2 cycles.

Reset
REQ-025 SHALL, on Rst_n=0, immediately force state IDLE, counter 0, ReqRdy=0 while Rst_n=0 then 1 after release, RspVal=0, RspErr=0, RspData=0, Ewr=0, Erd=0, Addr=0, RDir=0.
REQ-026 SHALL abort any in-flight transaction on reset mid-operation with no further Ewr/Erd pulse and no response.

Configuration
REQ-027 SHALL support macro DMEM_CTRL_BOUND_CHECK_EN: when defined, a request with ReqAddr[31:2] >= DEPTH goes to ERR (RspErr=1, no memory access).
REQ-028 SHALL, when DMEM_CTRL_BOUND_CHECK_EN is undefined, perform no range check; out-of-range word indices are passed unchanged on Addr.

Verification
REQ-029 Store: ReqVal=1, ReqWr=1, ReqAddr=0x10, ReqData=0xDEADBEEF -> one cycle Ewr=1, Addr=4, RDir=0xDEADBEEF; next cycle RspVal=1, RspErr=0, RspData=0.
REQ-030 Load after store, RD_LAT=1, memory model returns stored word: ReqAddr=0x10, ReqWr=0 -> Erd=1 one cycle with Addr=4; next cycle RspVal=1, RspData=0xDEADBEEF.
REQ-031 Misaligned: ReqAddr=0x13 -> RspVal=1, RspErr=1 one cycle after acceptance; Ewr=Erd=0 throughout.
REQ-032 Backpressure: RspRdy=0 for 5 cycles during RESP -> RspVal/RspData held stable 5 cycles, ReqRdy=0, a concurrent ReqVal pulse ignored; RspRdy=1 -> IDLE next edge.
REQ-033 Bound check with macro defined, DEPTH=32: ReqAddr=0x80 -> RspErr=1, no access; without macro -> Erd=1 with Addr=32.
REQ-034 Reset mid-load, RD_LAT=3: Rst_n=0 in second Erd cycle -> Erd=0 immediately, RspVal never asserted, ReqRdy=1 first cycle after release.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: request/response handshake to a word-addressed SRAM.
// Optional word-index range check enabled by defining DMEM_CTRL_BOUND_CHECK_EN.
module dmem_ctrl #(
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqVal,
  output logic        ReqRdy,
  input  logic        ReqWr,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  output logic        RspVal,
  input  logic        RspRdy,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic        Ewr,
  output logic        Erd,
  output logic [31:0] Addr,
  output logic [31:0] RDir,
  input  logic [31:0] MOut
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] RESP = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);
`ifdef DMEM_CTRL_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [31:0] wdata;
  logic        oor, bad;

  assign oor = {2'b00, ReqAddr[31:2]} >= 32'(DEPTH);
  assign bad = (ReqAddr[1:0] != 2'b00) || (BOUND_EN && oor);

  // Ready is gated by reset so nothing is accepted while the block is held.
  assign ReqRdy = (state == IDLE) && Rst_n;
  assign RspVal = (state == RESP) || (state == ERR);
  assign Ewr    = (state == WR);
  assign Erd    = (state == RD);
  assign RDir   = Ewr ? wdata : 32'h0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wdata   <= 32'h0;
      Addr    <= 32'h0;
      RspData <= 32'h0;
      RspErr  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ReqVal) begin
          Addr    <= {2'b00, ReqAddr[31:2]};
          wdata   <= ReqData;
          cnt     <= LAT_M1;
          RspData <= 32'h0;
          RspErr  <= bad;
          state   <= bad ? ERR : (ReqWr ? WR : RD);
        end
        WR: begin
          RspData <= 32'h0;
          RspErr  <= 1'b0;
          state   <= RESP;
        end
        // Erd stays high RD_LAT cycles; read data is captured on the last one.
        RD: begin
          if (cnt == 4'd0) begin
            RspData <= MOut;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP, ERR: if (RspRdy) begin
          RspData <= 32'h0;
          RspErr  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed stores/loads/errors, backpressure and mid-load reset.
module tb_dmem_ctrl;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ReqVal, ReqWr, RspRdy;
  logic [31:0] ReqAddr, ReqData;
  logic        ReqRdy, RspVal, RspErr, Ewr, Erd;
  logic [31:0] RspData, Addr, RDir, MOut;
  logic        rdy3, val3, err3, ewr3, erd3;
  logic [31:0] data3, addr3, rdir3;
  logic [31:0] mout3 = 32'hCAFE0000;

  logic [31:0] mem [0:63];
  logic [32:0] sb[$];
  logic [32:0] mexp;
  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  dmem_ctrl #(.DEPTH(32), .RD_LAT(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqVal(ReqVal), .ReqRdy(ReqRdy), .ReqWr(ReqWr),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspVal(RspVal), .RspRdy(RspRdy),
    .RspData(RspData), .RspErr(RspErr), .Ewr(Ewr), .Erd(Erd), .Addr(Addr),
    .RDir(RDir), .MOut(MOut));

  // Second instance with a longer read latency, used for the mid-load reset case.
  dmem_ctrl #(.DEPTH(32), .RD_LAT(3)) u_dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .ReqVal(ReqVal), .ReqRdy(rdy3), .ReqWr(ReqWr),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RspVal(val3), .RspRdy(RspRdy),
    .RspData(data3), .RspErr(err3), .Ewr(ewr3), .Erd(erd3), .Addr(addr3),
    .RDir(rdir3), .MOut(mout3));

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (Ewr) begin
      mem[Addr[5:0]] <= RDir;
    end
  end
  assign MOut = mem[Addr[5:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n && RspVal && RspRdy) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data %h err %b expected none", RspData, RspErr);
      end else begin
        mexp = sb.pop_front();
        chk("rsp_data", RspData, mexp[31:0]);
        chk("rsp_err", {31'b0, RspErr}, {31'b0, mexp[32]});
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                        input int exp_wr, input int exp_rd, input logic [31:0] exp_addr);
    int n, nwr, nrd, k;
    logic ok;
    @(negedge Clk);
    chk("req_rdy", {31'b0, ReqRdy}, 32'd1);
    ReqVal = 1'b1; ReqWr = wr; ReqAddr = addr; ReqData = data;
    sb.push_back({exp_e, exp_d});
    @(negedge Clk);
    ReqVal = 1'b0;
    n = 1; nwr = 0; nrd = 0; ok = 1'b1;
    while (!RspVal && n < 40) begin
      if (Ewr) begin
        nwr++;
        if (Addr !== exp_addr || RDir !== data) ok = 1'b0;
      end else if (RDir !== 32'h0) ok = 1'b0;
      if (Erd) begin
        nrd++;
        if (Addr !== exp_addr) ok = 1'b0;
      end
      if (Ewr && Erd) ok = 1'b0;
      if (ReqRdy) ok = 1'b0;
      @(negedge Clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("ewr_cycles", 32'(nwr), 32'(exp_wr));
    chk("erd_cycles", 32'(nrd), 32'(exp_rd));
    chk("mem_side", {31'b0, ok}, 32'd1);
    k = 0;
    while (RspVal && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("rsp_release", {31'b0, RspVal}, 32'd0);
  endtask

  initial begin
    Rst_n = 1'b0; RspRdy = 1'b1; ReqVal = 1'b0; ReqWr = 1'b0;
    ReqAddr = 32'h0; ReqData = 32'h0;
    #12;
    chk("rst_reqrdy", {31'b0, ReqRdy}, 32'd0);
    chk("rst_rspval", {31'b0, RspVal}, 32'd0);
    chk("rst_rsperr", {31'b0, RspErr}, 32'd0);
    chk("rst_rspdata", RspData, 32'h0);
    chk("rst_ewr_erd", {30'b0, Ewr, Erd}, 32'd0);
    chk("rst_addr", Addr, 32'h0);
    chk("rst_rdir", RDir, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 chk("rel_reqrdy", {31'b0, ReqRdy}, 32'd1);

    // wr, addr, data, exp_data, exp_err, latency, ewr cycles, erd cycles, word addr
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 0, 32'd4);
    do_req(1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1, 32'd4);
    do_req(1'b0, 32'h08, 32'h0,        32'h10000002, 1'b0, 2, 0, 1, 32'd2);
    do_req(1'b1, 32'h3C, 32'h12345678, 32'h0,        1'b0, 2, 1, 0, 32'd15);
    do_req(1'b0, 32'h3C, 32'h0,        32'h12345678, 1'b0, 2, 0, 1, 32'd15);
    do_req(1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd4);
    do_req(1'b1, 32'h22, 32'h55AA55AA, 32'h0,        1'b1, 1, 0, 0, 32'd8);
`ifdef DMEM_CTRL_BOUND_CHECK_EN
    do_req(1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'd32);
`else
    do_req(1'b0, 32'h80, 32'h0,        32'h10000020, 1'b0, 2, 0, 1, 32'd32);
`endif
    chk("misaligned_no_write", mem[8], 32'h10000008);

    // Backpressure: response held while RspRdy is low, extra request ignored.
    @(negedge Clk);
    RspRdy = 1'b0;
    ReqVal = 1'b1; ReqWr = 1'b0; ReqAddr = 32'h10;
    sb.push_back({1'b0, 32'hDEADBEEF});
    @(negedge Clk);
    ReqVal = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_val", {31'b0, RspVal}, 32'd1);
      chk("bp_data", RspData, 32'hDEADBEEF);
      chk("bp_rdy", {31'b0, ReqRdy}, 32'd0);
      chk("bp_mem_idle", {30'b0, Ewr, Erd}, 32'd0);
      if (i == 1) begin
        ReqVal = 1'b1; ReqWr = 1'b1; ReqAddr = 32'h20; ReqData = 32'h00000BAD;
      end else begin
        ReqVal = 1'b0;
      end
      @(negedge Clk);
    end
    @(posedge Clk);
    #1 RspRdy = 1'b1;
    @(negedge Clk);
    chk("bp_hold_last", {31'b0, RspVal}, 32'd1);
    @(negedge Clk);
    chk("bp_idle_rdy", {31'b0, ReqRdy}, 32'd1);
    chk("bp_idle_val", {31'b0, RspVal}, 32'd0);
    chk("bp_ignored_req", mem[8], 32'h10000008);

    // Reset in the second Erd cycle of an RD_LAT=3 load.
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    RspRdy = 1'b0;
    ReqVal = 1'b1; ReqWr = 1'b0; ReqAddr = 32'h10;
    @(negedge Clk);
    ReqVal = 1'b0;
    chk("rl_erd_1", {31'b0, erd3}, 32'd1);
    @(negedge Clk);
    chk("rl_erd_2", {31'b0, erd3}, 32'd1);
    chk("rl_addr", addr3, 32'd4);
    Rst_n = 1'b0;
    #1;
    chk("rl_erd_drop", {31'b0, erd3}, 32'd0);
    chk("rl_rdy_low", {31'b0, rdy3}, 32'd0);
    chk("rl_outs_clr", {29'b0, val3, err3, ewr3}, 32'd0);
    chk("rl_addr_clr", addr3, 32'h0);
    chk("rl_data_clr", data3 | rdir3, 32'h0);
    @(negedge Clk);
    chk("rl_val_inrst", {31'b0, val3}, 32'd0);
    Rst_n = 1'b1;
    #1 chk("rl_rdy_release", {31'b0, rdy3}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("rl_no_rsp", {31'b0, val3}, 32'd0);
      chk("rl_no_access", {30'b0, erd3, ewr3}, 32'd0);
    end
    RspRdy = 1'b1;
    @(negedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
